// File: rtl/mem_port_arbiter.sv
// Shares one single-port word memory between fetch (i_*) and load/store (d_*) requesters.
// Latency: gnt at N, strobe at N+1, rvalid at N+2; data wins unless fetch has starved STARVE_LIMIT grants.
module mem_port_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_gnt,
   output logic        i_rvalid,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic [31:0] mem_addr,
   output logic        mem_r_enable,
   output logic        mem_w_enable,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t           state_q;
   logic             owner_q;       // 1 = data side owns the access in flight
   logic             we_q;
   logic             err_q;
   logic [31:0]      addr_q;
   logic [31:0]      wdata_q;
   logic [CNT_W-1:0] starve_q;
   logic             mem_re_q;
   logic             mem_we_q;
   logic             i_rv_q;
   logic             d_rv_q;

   logic arb_en;
   logic lim_hit;
   logic d_win;
   logic i_win;
   logic d_misal;

   assign arb_en  = (state_q == IDLE) || (state_q == RESP);
   assign lim_hit = (starve_q == CNT_W'(STARVE_LIMIT));
   assign d_win   = arb_en && d_req && !(i_req && lim_hit);
   assign i_win   = arb_en && i_req && !d_win;
   assign d_misal = |d_addr[1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         owner_q  <= 1'b0;
         we_q     <= 1'b0;
         err_q    <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         starve_q <= '0;
         mem_re_q <= 1'b0;
         mem_we_q <= 1'b0;
         i_rv_q   <= 1'b0;
         d_rv_q   <= 1'b0;
      end else begin
         mem_re_q <= 1'b0;
         mem_we_q <= 1'b0;
         i_rv_q   <= 1'b0;
         d_rv_q   <= 1'b0;

         // Counter only grows while fetch is actually waiting; it tops out at the limit.
         if (!i_req || i_win)
            starve_q <= '0;
         else if (d_win && !lim_hit)
            starve_q <= starve_q + 1'b1;

         case (state_q)
            IDLE, RESP: begin
               if (d_win) begin
                  owner_q  <= 1'b1;
                  we_q     <= d_we;
                  err_q    <= d_misal;
                  addr_q   <= d_addr;
                  wdata_q  <= d_wdata;
                  mem_re_q <= !d_we && !d_misal;
                  mem_we_q <= d_we && !d_misal;
                  state_q  <= ISSUE;
               end else if (i_win) begin
                  owner_q  <= 1'b0;
                  we_q     <= 1'b0;
                  err_q    <= 1'b0;
                  addr_q   <= i_addr;
                  wdata_q  <= '0;
                  mem_re_q <= 1'b1;
                  state_q  <= ISSUE;
               end else begin
                  state_q  <= IDLE;
               end
            end
            ISSUE: begin
               i_rv_q  <= !owner_q;
               d_rv_q  <= owner_q;
               state_q <= RESP;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign i_gnt        = i_win;
   assign d_gnt        = d_win;
   assign mem_r_enable = mem_re_q;
   assign mem_w_enable = mem_we_q;
   assign mem_addr     = (state_q == ISSUE) ? addr_q : '0;
   assign mem_wdata    = (state_q == ISSUE && we_q) ? wdata_q : '0;
   assign i_rvalid     = i_rv_q;
   assign i_rdata      = i_rv_q ? mem_rdata : '0;
   assign d_rvalid     = d_rv_q;
   assign d_rdata      = (d_rv_q && !we_q && !err_q) ? mem_rdata : '0;
   assign d_err        = d_rv_q && err_q;
   assign busy         = (state_q != IDLE);

endmodule
